cpu_multicycle_param: RTL and testbench

//  Parametrised multi-cycle CPU core: register file, ALU, flags, PC and control FSM in one block.

---
 rtl/cpu_multicycle_param_if.sv | 25 ++
 rtl/cpu_multicycle_param.sv | 135 +++++++++++++
 tb/tb_cpu_multicycle_param.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_multicycle_param_if.sv
// cpu_multicycle_param_if: instruction-fetch and data-memory handshake bundle
interface cpu_multicycle_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int INS_W  = 16
);
  logic              ins_req;
  logic [ADDR_W-1:0] ins_addr;
  logic              ins_ack;
  logic [INS_W-1:0]  ins;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  modport master (
    output ins_req, ins_addr, mem_req, mem_we, mem_addr, mem_wdata,
    input  ins_ack, ins, mem_rdata, mem_ack
  );
  modport slave (
    input  ins_req, ins_addr, mem_req, mem_we, mem_addr, mem_wdata,
    output ins_ack, ins, mem_rdata, mem_ack
  );
endinterface

// File: rtl/cpu_multicycle_param.sv
// cpu_multicycle_param: parametrised multi-cycle CPU with fetch and data-memory handshakes
module cpu_multicycle_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int REG_AW = 2,
  parameter int IMM_W  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en_in,
  cpu_multicycle_param_if.master bus,
  output logic retire,
  output logic halted,
  output logic flag_z,
  output logic flag_c
);
  localparam int NREG  = 2 ** REG_AW;
  localparam int INS_W = 4 + 2 * REG_AW + IMM_W;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d;
  logic [INS_W-1:0]  ins_q, ins_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              z_q, z_d, c_q, c_d, retire_q, retire_d, mem_we_q, mem_we_d;
  logic [3:0]        op;
  logic [REG_AW-1:0] rd, rs;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] rd_v, rs_v, sx, zx;
  logic [DATA_W:0]   alu;
  logic              is_mem, wr_en, fl_en;
  assign {op, rd, rs, imm} = ins_q;
  assign rd_v   = regs_q[rd];
  assign rs_v   = regs_q[rs];
  assign sx     = DATA_W'($signed(imm));
  assign zx     = DATA_W'(imm);
  assign is_mem = op == 4'h8 || op == 4'h9;
  assign wr_en  = op inside {[4'h1:4'h7], 4'hC, 4'hD};
  assign fl_en  = op inside {[4'h1:4'h5], 4'h7, 4'hC, 4'hD};
  // ALU: carry/borrow rides in the extra top bit so flags fall out of one result
  always_comb begin
    case (op)
      4'h1:    alu = {1'b0, rd_v} + {1'b0, rs_v};
      4'h2:    alu = {1'b0, rd_v} - {1'b0, rs_v};
      4'h3:    alu = {1'b0, rd_v & rs_v};
      4'h4:    alu = {1'b0, rd_v | rs_v};
      4'h5:    alu = {1'b0, rd_v ^ rs_v};
      4'h6:    alu = {1'b0, zx};
      4'h7:    alu = {1'b0, rd_v} + {1'b0, sx};
      4'hC:    alu = {rd_v, 1'b0};
      4'hD:    alu = {rd_v[0], 1'b0, rd_v[DATA_W-1:1]};
      default: alu = {1'b0, rd_v};
    endcase
  end
  // control FSM: fetch, execute, optional memory phase; all architectural updates here
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ins_d       = ins_q;
    regs_d      = regs_q;
    z_d         = z_q;
    c_d         = c_q;
    retire_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE:  state_d = en_in ? S_FETCH : S_IDLE;
      S_FETCH: begin
        ins_d   = bus.ins_ack ? bus.ins : ins_q;
        state_d = bus.ins_ack ? S_EXEC : S_FETCH;
      end
      S_EXEC: begin
        retire_d    = !is_mem;
        state_d     = is_mem ? S_MEM : op == 4'hF ? S_HALT : S_FETCH;
        pc_d        = op == 4'hA ? ADDR_W'(imm) :
                      op == 4'hB && z_q ? pc_q + ADDR_W'(1) + ADDR_W'($signed(imm)) :
                      op == 4'hF ? pc_q : pc_q + ADDR_W'(1);
        mem_we_d    = op == 4'h9;
        mem_addr_d  = ADDR_W'(rs_v + sx);
        mem_wdata_d = rd_v;
        if (wr_en) regs_d[rd] = alu[DATA_W-1:0];
        z_d = fl_en ? alu[DATA_W-1:0] == '0 : z_q;
        c_d = fl_en ? alu[DATA_W] : c_q;
      end
      S_MEM: begin
        if (bus.mem_ack && !mem_we_q) regs_d[rd] = bus.mem_rdata;
        retire_d = bus.mem_ack;
        state_d  = bus.mem_ack ? S_FETCH : S_MEM;
      end
      default: state_d = state_q;
    endcase
  end
  // state registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ins_q       <= '0;
      regs_q      <= '{default: '0};
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      retire_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ins_q       <= ins_d;
      regs_q      <= regs_d;
      z_q         <= z_d;
      c_q         <= c_d;
      retire_q    <= retire_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  assign bus.ins_req   = state_q == S_FETCH;
  assign bus.ins_addr  = pc_q;
  assign bus.mem_req   = state_q == S_MEM;
  assign bus.mem_we    = state_q == S_MEM && mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign retire        = retire_q;
  assign halted        = state_q == S_HALT;
  assign flag_z        = z_q;
  assign flag_c        = c_q;
endmodule

// File: tb/tb_cpu_multicycle_param.sv
// tb_cpu_multicycle_param: table vectors, directed corner sequences and random programs vs an ISA model
module tb_cpu_multicycle_param;
  logic clk = 0, rst = 0, en_in = 0;
  logic retire, halted, flag_z, flag_c;
  cpu_multicycle_param_if #(.DATA_W(16), .ADDR_W(8), .INS_W(16)) bus();
  cpu_multicycle_param dut (
    .clk(clk), .rst(rst), .en_in(en_in), .bus(bus),
    .retire(retire), .halted(halted), .flag_z(flag_z), .flag_c(flag_c)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b, r;
    logic        z, c;
    string       name;
  } vec_t;
  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  logic [15:0] dmem_init [256];
  logic [9:0]  act_f[$], exp_f[$];
  logic [24:0] act_m[$], exp_m[$];
  int n_cmp = 0, n_bad = 0;
  int ins_wait = 0, mem_wait = 0, icnt = 0, mcnt = 0, rcnt = 0, rviol = 0, sviol = 0;
  bit rand_w = 0, iprev = 0, mprev = 0;
  logic [7:0]  iaddr_p;
  logic [24:0] mreq_p;
  logic mz, mc;
  // memory responder followed by protocol monitor, both on the falling edge
  always @(negedge clk) begin
    if (bus.ins_req) begin
      if (icnt >= ins_wait) begin
        bus.ins_ack = 1; bus.ins = imem[bus.ins_addr]; icnt = 0;
        if (rand_w) ins_wait = $urandom_range(0, 3);
      end else begin bus.ins_ack = 0; icnt++; end
    end else begin bus.ins_ack = 0; icnt = 0; end
    if (bus.mem_req) begin
      if (mcnt >= mem_wait) begin
        bus.mem_ack = 1; mcnt = 0;
        if (bus.mem_we) begin
          dmem[bus.mem_addr] = bus.mem_wdata;
          act_m.push_back({1'b1, bus.mem_addr, bus.mem_wdata});
        end else begin
          bus.mem_rdata = dmem[bus.mem_addr];
          act_m.push_back({1'b0, bus.mem_addr, dmem[bus.mem_addr]});
        end
        if (rand_w) mem_wait = $urandom_range(0, 3);
      end else begin bus.mem_ack = 0; mcnt++; end
    end else begin bus.mem_ack = 0; mcnt = 0; end
    if (rst) begin
      if (retire) rcnt++;
      if (bus.ins_req && iprev && bus.ins_addr != iaddr_p) sviol++;
      if (bus.mem_req && mprev && {bus.mem_we, bus.mem_addr, bus.mem_wdata} != mreq_p) sviol++;
      iprev = bus.ins_req; iaddr_p = bus.ins_addr;
      mprev = bus.mem_req; mreq_p = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
      if (bus.ins_req && bus.ins_ack) begin
        if (act_f.size() > 0 && rcnt != 1) rviol++;
        rcnt = 0;
        act_f.push_back({bus.ins_addr, flag_z, flag_c});
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk); #1;
  endtask
  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s, input logic [7:0] im);
    return {op, d, s, im};
  endfunction
  task automatic clear_mem();
    foreach (imem[i]) imem[i] = 16'hF000;
    foreach (dmem_init[i]) dmem_init[i] = 16'h5A5A;
  endtask
  task automatic start_prog();
    rst = 0; en_in = 0;
    act_f.delete(); act_m.delete();
    rcnt = 0; rviol = 0; sviol = 0; iprev = 0; mprev = 0;
    foreach (dmem[i]) dmem[i] = dmem_init[i];
    tick(); tick(); rst = 1; tick(); en_in = 1; tick(); en_in = 0;
  endtask
  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin tick(); n++; end
    if (!halted) chk("halt_timeout", 0, 1);
  endtask
  // instruction-level reference: executes the program one architectural step at a time
  task automatic model_run();
    logic [15:0] r [4];
    logic [15:0] dm [256];
    logic [7:0]  pc, ad, im;
    logic [3:0]  op;
    logic [1:0]  d, s;
    logic [15:0] sx, a, b, res;
    logic        z, c;
    int unsigned t;
    bit          fl;
    r = '{default: '0}; pc = 0; z = 0; c = 0;
    exp_f.delete(); exp_m.delete();
    foreach (dm[i]) dm[i] = dmem_init[i];
    for (int k = 0; k < 500; k++) begin
      exp_f.push_back({pc, z, c});
      {op, d, s, im} = imem[pc];
      sx = {{8{im[7]}}, im};
      a = r[d]; b = r[s]; fl = 1; res = a;
      if (op == 4'hF) break;
      case (op)
        4'h1: begin t = int'(a) + int'(b); res = 16'(t); c = t > 65535; end
        4'h2: begin res = a - b; c = a < b; end
        4'h3: begin res = a & b; c = 0; end
        4'h4: begin res = a | b; c = 0; end
        4'h5: begin res = a ^ b; c = 0; end
        4'h7: begin t = int'(a) + int'(sx); res = 16'(t); c = t > 65535; end
        4'hC: begin res = 16'(int'(a) * 2); c = a >= 16'h8000; end
        4'hD: begin res = a / 2; c = a % 2 == 1; end
        default: fl = 0;
      endcase
      if (fl) begin r[d] = res; z = res == 0; end
      if (op == 4'h6) r[d] = {8'h00, im};
      ad = 8'(int'(b) + int'(sx));
      if (op == 4'h8) begin exp_m.push_back({1'b0, ad, dm[ad]}); r[d] = dm[ad]; end
      if (op == 4'h9) begin exp_m.push_back({1'b1, ad, a}); dm[ad] = a; end
      pc = op == 4'hA ? im : (op == 4'hB && z) ? 8'(int'(pc) + 1 + int'(sx)) : pc + 8'd1;
    end
    mz = z; mc = c;
  endtask
  task automatic cmp_model(input string tag);
    model_run();
    chk({tag, "_nfetch"}, act_f.size(), exp_f.size());
    for (int i = 0; i < act_f.size() && i < exp_f.size(); i++)
      chk($sformatf("%s_fetch%0d", tag, i), act_f[i], exp_f[i]);
    chk({tag, "_nmem"}, act_m.size(), exp_m.size());
    for (int i = 0; i < act_m.size() && i < exp_m.size(); i++)
      chk($sformatf("%s_mem%0d", tag, i), act_m[i], exp_m[i]);
    chk({tag, "_flags"}, {flag_z, flag_c}, {mz, mc});
    chk({tag, "_stable"}, sviol, 0);
    chk({tag, "_retire"}, rviol, 0);
  endtask
  initial begin
    vec_t tbl [12];
    logic [3:0] ops [13];
    logic [7:0] seq_a [7];
    logic [7:0] seq_b [7];
    int n, n0, reqs;
    bus.ins_ack = 0; bus.ins = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    tbl[0]  = '{4'h1, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, "add_small"};
    tbl[1]  = '{4'h1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, "add_ovf"};
    tbl[2]  = '{4'h2, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, "sub_borrow"};
    tbl[3]  = '{4'h2, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, "sub_eq"};
    tbl[4]  = '{4'h2, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, "sub_plain"};
    tbl[5]  = '{4'h3, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, "and"};
    tbl[6]  = '{4'h4, 16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b0, "or"};
    tbl[7]  = '{4'h5, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0, "xor_zero"};
    tbl[8]  = '{4'hC, 16'h8001, 16'h0000, 16'h0002, 1'b0, 1'b1, "shl_msb"};
    tbl[9]  = '{4'hC, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b1, "shl_zero"};
    tbl[10] = '{4'hD, 16'h0003, 16'h0000, 16'h0001, 1'b0, 1'b1, "shr_lsb"};
    tbl[11] = '{4'h1, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, "add_msb"};
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE};
    seq_a = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h04, 8'h05, 8'h06};
    seq_b = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'h00, 8'h10};
    // reset while a fetch is stalled
    clear_mem();
    imem[0] = enc(4'h6, 0, 0, 8'h00); imem[1] = enc(4'h6, 1, 0, 8'h01);
    imem[2] = enc(4'h2, 0, 1, 8'h00); imem[3] = 16'h0000;
    start_prog();
    n = 0;
    while (act_f.size() < 3 && n < 50) begin tick(); n++; end
    ins_wait = 20;
    repeat (4) tick();
    chk("t1_pre_req", bus.ins_req, 1);
    chk("t1_pre_addr", bus.ins_addr, 8'h03);
    chk("t1_pre_c", flag_c, 1);
    rst = 0; #1;
    chk("t1_req", bus.ins_req, 0);
    chk("t1_addr", bus.ins_addr, 0);
    chk("t1_flags", {flag_z, flag_c}, 0);
    chk("t1_halted", halted, 0);
    chk("t1_mem_retire", {bus.mem_req, retire}, 0);
    ins_wait = 0;
    // table-driven ALU vectors: operands loaded from memory, result stored back
    foreach (tbl[i]) begin
      clear_mem();
      dmem_init[0] = tbl[i].a; dmem_init[1] = tbl[i].b;
      imem[0] = enc(4'h8, 0, 3, 8'h00); imem[1] = enc(4'h8, 1, 3, 8'h01);
      imem[2] = enc(tbl[i].op, 0, 1, 8'h00); imem[3] = enc(4'h9, 0, 3, 8'h02);
      start_prog(); wait_halt(200);
      chk({tbl[i].name, "_res"}, dmem[2], tbl[i].r);
      chk({tbl[i].name, "_flags"}, {flag_z, flag_c}, {tbl[i].z, tbl[i].c});
    end
    // ALU/flag walk with shifts and same-register subtract
    clear_mem();
    imem[0] = enc(4'h6, 0, 0, 8'hFF); imem[1] = enc(4'h6, 1, 0, 8'h01);
    imem[2] = enc(4'h1, 0, 1, 8'h00); imem[3] = enc(4'h9, 0, 3, 8'h20);
    imem[4] = enc(4'h6, 2, 0, 8'hFF);
    for (int i = 5; i < 13; i++) imem[i] = enc(4'hC, 2, 0, 8'h00);
    imem[13] = enc(4'h7, 2, 0, 8'h01); imem[14] = enc(4'h9, 2, 3, 8'h21);
    imem[15] = enc(4'h2, 1, 1, 8'h00); imem[16] = enc(4'h9, 1, 3, 8'h22);
    start_prog(); wait_halt(300);
    chk("t2_add", dmem[8'h20], 16'h0100);
    chk("t2_shl_addi", dmem[8'h21], 16'hFF01);
    chk("t2_sub_self", dmem[8'h22], 16'h0000);
    chk("t2_add_flags", act_f.size() > 3 ? act_f[3] : 10'h3FF, {8'h03, 2'b00});
    chk("t2_addi_flags", act_f.size() > 14 ? act_f[14] : 10'h3FF, {8'h0E, 2'b00});
    chk("t2_final_flags", {flag_z, flag_c}, 2'b10);
    cmp_model("t2");
    // fetch and load stalls
    clear_mem();
    dmem_init[8'h12] = 16'hBEEF;
    imem[0] = enc(4'h6, 1, 0, 8'h10); imem[1] = enc(4'h8, 3, 1, 8'h02);
    imem[2] = enc(4'h9, 3, 0, 8'h30);
    ins_wait = 5; mem_wait = 3;
    start_prog(); wait_halt(300);
    chk("t4_ld_access", act_m.size() > 0 ? act_m[0] : 25'h0, {1'b0, 8'h12, 16'hBEEF});
    chk("t4_st_data", dmem[8'h30], 16'hBEEF);
    cmp_model("t4");
    ins_wait = 0; mem_wait = 0;
    // backward branch taken then not taken
    clear_mem();
    imem[0] = enc(4'h6, 0, 0, 8'h00); imem[1] = enc(4'h7, 0, 0, 8'h00);
    imem[2] = enc(4'hA, 0, 0, 8'h05); imem[4] = enc(4'h7, 0, 0, 8'h01);
    imem[5] = enc(4'hB, 0, 0, 8'hFE);
    start_prog(); wait_halt(200);
    foreach (seq_a[i]) chk($sformatf("t5a_pc%0d", i), act_f.size() > i ? act_f[i][9:2] : 8'hXX, seq_a[i]);
    cmp_model("t5a");
    // PC wrap from 0xFF, forward branch on second visit
    clear_mem();
    imem[0] = enc(4'hB, 0, 0, 8'h0F); imem[1] = enc(4'h6, 0, 0, 8'h00);
    imem[2] = enc(4'h7, 0, 0, 8'h00); imem[3] = enc(4'hA, 0, 0, 8'hFF);
    imem[8'hFF] = 16'h0000;
    start_prog(); wait_halt(200);
    foreach (seq_b[i]) chk($sformatf("t5b_pc%0d", i), act_f.size() > i ? act_f[i][9:2] : 8'hXX, seq_b[i]);
    cmp_model("t5b");
    // HALT is sticky until reset
    clear_mem();
    for (int i = 0; i < 7; i++) imem[i] = 16'h0000;
    start_prog(); wait_halt(200);
    chk("t6_halted", halted, 1);
    chk("t6_last_fetch", act_f.size() > 0 ? act_f[act_f.size()-1][9:2] : 8'h00, 8'h07);
    n0 = act_f.size(); reqs = 0;
    en_in = 1; repeat (3) tick(); en_in = 0;
    repeat (10) begin tick(); if (bus.ins_req) reqs++; end
    chk("t6_no_fetch", act_f.size() - n0 + reqs, 0);
    chk("t6_still_halted", halted, 1);
    rst = 0; #1;
    chk("t6_reset_exit", halted, 0);
    // random programs with random handshake delays
    rand_w = 1;
    for (int p = 0; p < 6; p++) begin
      clear_mem();
      foreach (dmem_init[i]) dmem_init[i] = 16'($urandom);
      for (int i = 0; i < 24; i++) imem[i] = {ops[$urandom_range(0, 12)], 12'($urandom)};
      for (int k = 0; k < 4; k++) imem[24+k] = enc(4'h9, 2'(k), 2'd0, 8'(8'hF0 + k));
      start_prog(); wait_halt(3000);
      cmp_model($sformatf("rnd%0d", p));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
